// File: rtl/cci_mpf_fiu_rsp_pkg.sv
// cci_mpf_fiu_rsp_pkg: shared types for the FIU responder
package cci_mpf_fiu_rsp_pkg;
  typedef logic [41:0] t_line_addr;
  typedef logic [15:0] t_mdata;
  typedef logic [511:0] t_line;
  typedef logic [7:0] t_ts;
  typedef enum logic {INIT, RUN} t_rsp_state;
endpackage

// File: rtl/cci_mpf_fiu_rsp_dly_fifo.sv
// cci_mpf_fiu_rsp_dly_fifo: timestamped FIFO releasing its head once it is exactly LATENCY cycles old
module cci_mpf_fiu_rsp_dly_fifo
  import cci_mpf_fiu_rsp_pkg::*;
#(
  parameter int W = 24,
  parameter int DEPTH = 64,
  parameter int AF_SLACK = 8,
  parameter int LATENCY = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic [7:0]               i_ts,
  output logic                     o_deq,
  output logic [W-1:0]             o_deq_data,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_af
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_data [DEPTH];
  t_ts r_stamp [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_wr, w_deq;
  t_ts w_age;
  assign w_wr = i_wr_en && r_cnt != (AW+1)'(DEPTH);
  assign w_age = i_ts - r_stamp[r_rp];
  assign w_deq = r_cnt != '0 && w_age == t_ts'(LATENCY);
  assign o_deq = w_deq;
  assign o_deq_data = r_data[r_rp];
  assign o_cnt = r_cnt;
  assign o_af = r_cnt >= (AW+1)'(DEPTH - AF_SLACK);
  // store payload and arrival stamp; storage needs no reset since occupancy gates it
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wp] <= i_wr_data;
      r_stamp[r_wp] <= i_ts;
    end
  end
  // pointers and occupancy; a write into a full FIFO is dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_deq);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_deq);
    end
  end
endmodule

// File: rtl/cci_mpf_fiu_responder.sv
// cci_mpf_fiu_responder: fixed-latency CCI read/write responder over a zero-initialised line memory (checks: CCI_MPF_FIU_RSP_CHECK_EN)
module cci_mpf_fiu_responder
  import cci_mpf_fiu_rsp_pkg::*;
#(
  parameter int READ_LATENCY = 24,
  parameter int WRITE_LATENCY = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_SLACK = 8,
  parameter int MEM_LINES = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          c0_req_valid,
  input  logic [41:0]   c0_req_addr,
  input  logic [15:0]   c0_req_mdata,
  input  logic          c1_req_valid,
  input  logic [41:0]   c1_req_addr,
  input  logic [15:0]   c1_req_mdata,
  input  logic [511:0]  c1_req_data,
  output logic          c0_almost_full,
  output logic          c1_almost_full,
  output logic          c0_rsp_valid,
  output logic [15:0]   c0_rsp_mdata,
  output logic [511:0]  c0_rsp_data,
  output logic          c1_rsp_valid,
  output logic [15:0]   c1_rsp_mdata,
  output logic          c0NotEmpty,
  output logic          c1NotEmpty
);
  localparam int IW = $clog2(MEM_LINES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int C0W = IW + 16;
  localparam int C1W = IW + 16 + 512;
  t_rsp_state r_state, w_state_nxt;
  logic [IW-1:0] r_line;
  t_ts r_ts;
  t_line r_mem [MEM_LINES];
  logic r_c0_rsp_valid, r_c1_rsp_valid, r_c0_ne, r_c1_ne;
  t_mdata r_c0_rsp_mdata, r_c1_rsp_mdata;
  t_line r_c0_rsp_data;
  logic w_run, w_c0_acc, w_c1_acc, w_c0_deq, w_c1_deq, w_c0_af, w_c1_af, w_ovf;
  logic [C0W-1:0] w_c0_head;
  logic [C1W-1:0] w_c1_head;
  logic [CW-1:0] w_c0_cnt, w_c1_cnt;
  logic [IW-1:0] w_c0_idx, w_c1_idx;
  logic w_unused;
  assign w_run = r_state == RUN;
  assign w_c0_acc = c0_req_valid && w_run;
  assign w_c1_acc = c1_req_valid && w_run;
  assign w_c0_idx = w_c0_head[C0W-1 -: IW];
  assign w_c1_idx = w_c1_head[C1W-1 -: IW];
  assign w_ovf = (w_c0_acc && w_c0_cnt == CW'(FIFO_DEPTH)) || (w_c1_acc && w_c1_cnt == CW'(FIFO_DEPTH));
  assign w_unused = ^{c0_req_addr[41:IW], c1_req_addr[41:IW]};
  cci_mpf_fiu_rsp_dly_fifo #(.W(C0W), .DEPTH(FIFO_DEPTH), .AF_SLACK(AF_SLACK), .LATENCY(READ_LATENCY)) u_c0_fifo (
    .clk(clk), .reset_n(reset_n), .i_wr_en(w_c0_acc), .i_wr_data({c0_req_addr[IW-1:0], c0_req_mdata}),
    .i_ts(r_ts), .o_deq(w_c0_deq), .o_deq_data(w_c0_head), .o_cnt(w_c0_cnt), .o_af(w_c0_af)
  );
  cci_mpf_fiu_rsp_dly_fifo #(.W(C1W), .DEPTH(FIFO_DEPTH), .AF_SLACK(AF_SLACK), .LATENCY(WRITE_LATENCY)) u_c1_fifo (
    .clk(clk), .reset_n(reset_n), .i_wr_en(w_c1_acc), .i_wr_data({c1_req_addr[IW-1:0], c1_req_mdata, c1_req_data}),
    .i_ts(r_ts), .o_deq(w_c1_deq), .o_deq_data(w_c1_head), .o_cnt(w_c1_cnt), .o_af(w_c1_af)
  );
  // INIT walks every line once, then the responder runs until the next reset
  always_comb begin
    w_state_nxt = (!w_run && r_line == IW'(MEM_LINES - 1)) ? RUN : r_state;
  end
  // state, init line pointer and free-running timestamp
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_line <= '0;
      r_ts <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line <= r_line + IW'(!w_run);
      r_ts <= r_ts + 8'd1;
    end
  end
  // zero lines during INIT, commit dequeued writes while running
  always_ff @(posedge clk) begin
    if (!w_run) r_mem[r_line] <= '0;
    else if (w_c1_deq) r_mem[w_c1_idx] <= w_c1_head[511:0];
  end
  // response strobes and activity flags; a reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c0_rsp_valid <= 1'b0;
      r_c1_rsp_valid <= 1'b0;
      r_c0_ne <= 1'b0;
      r_c1_ne <= 1'b0;
    end else begin
      r_c0_rsp_valid <= w_c0_deq;
      r_c1_rsp_valid <= w_c1_deq;
      r_c0_ne <= w_c0_cnt != '0 || w_c0_acc;
      r_c1_ne <= w_c1_cnt != '0 || w_c1_acc;
    end
  end
  // response payloads; the read sees the line before a same-cycle write lands
  always_ff @(posedge clk) begin
    if (w_c0_deq) begin
      r_c0_rsp_mdata <= w_c0_head[15:0];
      r_c0_rsp_data <= r_mem[w_c0_idx];
    end
    if (w_c1_deq) r_c1_rsp_mdata <= w_c1_head[527:512];
  end
  assign c0_almost_full = !w_run || w_c0_af;
  assign c1_almost_full = !w_run || w_c1_af;
  assign c0_rsp_valid = r_c0_rsp_valid;
  assign c0_rsp_mdata = r_c0_rsp_mdata;
  assign c0_rsp_data = r_c0_rsp_data;
  assign c1_rsp_valid = r_c1_rsp_valid;
  assign c1_rsp_mdata = r_c1_rsp_mdata;
  assign c0NotEmpty = r_c0_ne;
  assign c1NotEmpty = r_c1_ne;
`ifdef CCI_MPF_FIU_RSP_CHECK_EN
  logic r_ovf;
  // overflow latches so every later cycle keeps reporting it
  always_ff @(posedge clk) begin
    if (!reset_n) r_ovf <= 1'b0;
    else begin
      if (w_ovf) r_ovf <= 1'b1;
      if (r_ovf) $error("request FIFO overflow, request dropped");
      if (!w_run && (c0_req_valid || c1_req_valid)) $error("request received during INIT");
    end
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 127) begin : g_bad_rd_lat
    $error("READ_LATENCY out of range 1..127");
  end
  if (WRITE_LATENCY < 1 || WRITE_LATENCY > 127) begin : g_bad_wr_lat
    $error("WRITE_LATENCY out of range 1..127");
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
`endif
endmodule
